// File: rtl/adder_gather.sv
// Serial-to-parallel gather: packs up to num samples into lanes o[0..num-1] for a downstream adder.
// Latency: a frame appears on o one cycle after its completing transfer. Throughput is one sample per cycle.
// Backpressure: ready is low only while rst is high.
module adder_gather #(
    parameter int bits = 8,
    parameter int num  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [bits-1:0]               i,
    input  logic                          last,
    output logic                          ready,
    output logic [num-1:0][bits-1:0]      o,
    output logic                          valid_out,
    output logic [$clog2(num+1)-1:0]      count_out
);
    localparam int IW = $clog2(num);
    localparam int CW = $clog2(num+1);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [num-1:0][bits-1:0] buf_q, buf_d;
    logic [num-1:0][bits-1:0] o_q, o_d;
    logic                     vout_q, vout_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     done;

    assign ready = ~rst;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        o_d     = o_q;
        vout_d  = 1'b0;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (valid && ready) begin
            done = last || (idx_q == IW'(num - 1));
            if (done) begin
                // Buffer lanes past idx_q are already zero, so unwritten lanes read as 0.
                o_d        = buf_q;
                o_d[idx_q] = i;
                buf_d      = '0;
                idx_d      = '0;
                vout_d     = 1'b1;
                cnt_d      = CW'(idx_q) + CW'(1);
                state_d    = IDLE;
            end else begin
                buf_d[idx_q] = i;
                idx_d        = idx_q + IW'(1);
                state_d      = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            o_q     <= '0;
            vout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            o_q     <= o_d;
            vout_q  <= vout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs read as zero for the whole time rst is high, including its first cycle.
    assign o         = rst ? '0 : o_q;
    assign valid_out = vout_q & ~rst;
    assign count_out = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_adder_gather.sv
// Randomized and directed bench for adder_gather against a queue-based frame model.
module tb_adder_gather;
    localparam int BITS = 8;
    localparam int NUM  = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       valid;
    logic [BITS-1:0]            i_dat;
    logic                       last;
    logic                       ready;
    logic [NUM-1:0][BITS-1:0]   o;
    logic                       valid_out;
    logic [$clog2(NUM+1)-1:0]   count_out;

    adder_gather #(.bits(BITS), .num(NUM)) dut (
        .clk(clk), .rst(rst), .valid(valid), .i(i_dat), .last(last),
        .ready(ready), .o(o), .valid_out(valid_out), .count_out(count_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pending samples of the open frame and the frame currently shown.
    logic [BITS-1:0] fill[$];
    logic [BITS-1:0] shown[NUM];
    int              shown_cnt = 0;
    bit              pend = 1'b0;
    int              pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [BITS-1:0] d, input bit l, input bit r);
        valid = v; i_dat = d; last = l; rst = r;
        #1;
        chk("ready", {31'd0, ready}, {31'd0, !r});
        if (r) begin
            chk("valid_out_in_rst", {31'd0, valid_out}, 32'd0);
            chk("count_out_in_rst", 32'(count_out), 32'd0);
        end
        pend = 1'b0;
        if (r) begin
            fill.delete();
            foreach (shown[k]) shown[k] = '0;
            shown_cnt = 0;
        end else if (v) begin
            fill.push_back(d);
            if (l || fill.size() == NUM) begin
                for (int k = 0; k < NUM; k++) shown[k] = (k < fill.size()) ? fill[k] : '0;
                shown_cnt = fill.size();
                pend = 1'b1;
                fill.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("valid_out", {31'd0, valid_out}, {31'd0, pend});
        if (valid_out) pulses++;
        chk("count_out", 32'(count_out), 32'(shown_cnt));
        for (int k = 0; k < NUM; k++) chk($sformatf("o%0d", k), 32'(o[k]), 32'(shown[k]));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; i_dat = '0; last = 1'b0;
        @(negedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Full frame 1..16.
        pulses = 0;
        for (int k = 1; k <= NUM; k++) step(1, k[BITS-1:0], 0, 0);
        chk("full_o15", 32'(o[15]), 32'd16);
        chk("full_cnt", 32'(count_out), 32'd16);
        step(0, 0, 0, 0);
        chk("full_pulses", 32'(pulses), 32'd1);

        // Early last after three samples.
        step(1, 8'h0A, 0, 0); step(1, 8'h0B, 0, 0); step(1, 8'h0C, 1, 0);
        chk("short_o2", 32'(o[2]), 32'h0C);
        chk("short_o3", 32'(o[3]), 32'd0);
        chk("short_cnt", 32'(count_out), 32'd3);

        // Valid low every other cycle.
        for (int k = 1; k <= NUM; k++) begin
            step(1, k[BITS-1:0], 0, 0);
            if (k != NUM) step(0, 8'hEE, 0, 0);
        end
        chk("sparse_cnt", 32'(count_out), 32'd16);

        // Two back-to-back frames 1..32.
        pulses = 0;
        for (int k = 1; k <= 2 * NUM; k++) step(1, k[BITS-1:0], 0, 0);
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_o0", 32'(o[0]), 32'd17);

        // Reset mid-frame discards the partial frame.
        pulses = 0;
        for (int k = 0; k < 5; k++) step(1, 8'h40 + k[BITS-1:0], 0, 0);
        step(0, 0, 0, 1);
        for (int k = 0; k < NUM; k++) step(1, 8'hF0 + k[BITS-1:0], 0, 0);
        chk("rst_pulses", 32'(pulses), 32'd1);
        chk("rst_o0", 32'(o[0]), 32'hF0);

        // One-lane frames, and reset in the cycle after a completion.
        step(1, 8'h55, 1, 0);
        chk("one_cnt", 32'(count_out), 32'd1);
        step(1, 8'h77, 1, 0);
        chk("one_next_o0", 32'(o[0]), 32'h77);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // last on the final lane completes exactly once.
        pulses = 0;
        for (int k = 0; k < NUM; k++) step(1, 8'h80 + k[BITS-1:0], k == NUM - 1, 0);
        step(0, 0, 0, 0);
        chk("last_at_end_pulses", 32'(pulses), 32'd1);

        for (int n = 0; n < 1500; n++)
            step($urandom_range(0, 9) < 7, BITS'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
